// File: rtl/axis_fork_route_decoder.sv
// Purpose: decodes per-packet destination mask / fork flag from the header beat, drops zero-mask packets.
// Latency: 1 cycle from input acceptance to m_axis_tvalid; 1 beat/cycle sustained.
// Backpressure: 2-entry register slice; s_axis_tready (registered) drops the cycle after the skid fills.
module axis_fork_route_decoder #(
  parameter int DATA_WIDTH = 64,
  parameter int M_COUNT    = 3,
  parameter int MASK_LSB   = 50,
  parameter int FORK_BIT   = 53,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [M_COUNT-1:0]    oen,
  output logic                  fork_enable,
  output logic [CNT_WIDTH-1:0]  drop_count,
  output logic                  busy
);

  typedef enum logic [1:0] {
    ST_HEAD = 2'd0,
    ST_PASS = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t                state;
  logic [M_COUNT-1:0]    pkt_mask;
  logic                  pkt_fk;

  // Skid register: holds the one beat that arrives while the output is stalled.
  logic [DATA_WIDTH-1:0] skid_dat;
  logic                  skid_last;
  logic [M_COUNT-1:0]    skid_oen;
  logic                  skid_fk;
  logic                  skid_vld;

  logic [M_COUNT-1:0]    hdr_mask;
  logic                  hdr_fk;
  logic                  in_accept;
  logic                  fwd;
  logic [M_COUNT-1:0]    beat_oen;
  logic                  beat_fk;
  logic                  out_free;
  logic                  skid_vld_nxt;

  // Header decode, forward decision and sideband selection for the beat at the input.
  always_comb begin
    hdr_mask  = s_axis_tdata[MASK_LSB +: M_COUNT];
    hdr_fk    = s_axis_tdata[FORK_BIT];
    in_accept = s_axis_tvalid && s_axis_tready;
    beat_oen  = pkt_mask;
    beat_fk   = pkt_fk;
    fwd       = 1'b0;
    case (state)
      ST_HEAD: begin
        beat_oen = hdr_mask;
        beat_fk  = hdr_fk;
        fwd      = in_accept && (hdr_mask != '0);
      end
      ST_PASS: fwd = in_accept;
      default: fwd = 1'b0;
    endcase
  end

  // The output register can take a new beat when it is empty or being consumed this cycle.
  always_comb begin
    out_free     = !m_axis_tvalid || m_axis_tready;
    skid_vld_nxt = skid_vld;
    if (out_free) begin
      skid_vld_nxt = 1'b0;
    end else if (fwd) begin
      skid_vld_nxt = 1'b1;
    end
  end

  // Packet FSM: latches the header sideband and counts dropped packets (saturating).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_HEAD;
      pkt_mask   <= '0;
      pkt_fk     <= 1'b0;
      drop_count <= '0;
    end else if (in_accept) begin
      case (state)
        ST_HEAD: begin
          pkt_mask <= hdr_mask;
          pkt_fk   <= hdr_fk;
          if (hdr_mask == '0) begin
            if (drop_count != CNT_MAX) begin
              drop_count <= drop_count + CNT_WIDTH'(1);
            end
            state <= s_axis_tlast ? ST_HEAD : ST_DROP;
          end else begin
            state <= s_axis_tlast ? ST_HEAD : ST_PASS;
          end
        end
        ST_PASS: if (s_axis_tlast) state <= ST_HEAD;
        ST_DROP: if (s_axis_tlast) state <= ST_HEAD;
        default: state <= ST_HEAD;
      endcase
    end
  end

  // Output register: the skid beat always drains first so ordering is preserved.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      oen           <= '0;
      fork_enable   <= 1'b0;
    end else if (out_free) begin
      if (skid_vld) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= skid_dat;
        m_axis_tlast  <= skid_last;
        oen           <= skid_oen;
        fork_enable   <= skid_fk;
      end else if (fwd) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= s_axis_tdata;
        m_axis_tlast  <= s_axis_tlast;
        oen           <= beat_oen;
        fork_enable   <= beat_fk;
      end else begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

  // Skid register: captures a forwarded beat only while the output is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_vld  <= 1'b0;
      skid_dat  <= '0;
      skid_last <= 1'b0;
      skid_oen  <= '0;
      skid_fk   <= 1'b0;
    end else begin
      skid_vld <= skid_vld_nxt;
      if (!out_free && fwd) begin
        skid_dat  <= s_axis_tdata;
        skid_last <= s_axis_tlast;
        skid_oen  <= beat_oen;
        skid_fk   <= beat_fk;
      end
    end
  end

  // Registered input ready: open whenever the skid will be empty next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_axis_tready <= 1'b0;
    end else begin
      s_axis_tready <= !skid_vld_nxt;
    end
  end

  // Busy while mid-packet at the input or holding any beat internally.
  always_comb begin
    busy = (state != ST_HEAD) || m_axis_tvalid || skid_vld;
  end

endmodule

// File: tb/tb_axis_fork_route_decoder.sv
// Purpose: directed, scoreboard-checked bench for axis_fork_route_decoder.
// Latency: expects output 1 cycle after acceptance.
// Backpressure: exercises a 5-cycle downstream stall mid-packet.
module tb_axis_fork_route_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] s_axis_tdata;
  logic        s_axis_tlast;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tlast;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [2:0]  oen;
  logic        fork_enable;
  logic [15:0] drop_count;
  logic        busy;

  logic        sat_s_tready;
  logic [63:0] sat_m_tdata;
  logic        sat_m_tlast;
  logic        sat_m_tvalid;
  logic [2:0]  sat_oen;
  logic        sat_fork_enable;
  logic [1:0]  sat_drop_count;
  logic        sat_busy;

  always #5 clk = ~clk;

  axis_fork_route_decoder dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .oen(oen), .fork_enable(fork_enable),
    .drop_count(drop_count), .busy(busy)
  );

  // Narrow-counter instance sharing the same stimulus, used for saturation.
  axis_fork_route_decoder #(.CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(sat_s_tready),
    .m_axis_tdata(sat_m_tdata), .m_axis_tlast(sat_m_tlast),
    .m_axis_tvalid(sat_m_tvalid), .m_axis_tready(m_axis_tready),
    .oen(sat_oen), .fork_enable(sat_fork_enable),
    .drop_count(sat_drop_count), .busy(sat_busy)
  );

  typedef struct packed {
    logic [63:0] data;
    logic        last;
    logic [2:0]  oen;
    logic        fk;
  } beat_t;

  beat_t exp_q[$];
  int    tests = 0;
  int    fails = 0;
  bit    lat_chk = 1'b1;

  function automatic logic [63:0] hdr(input logic [2:0] mask, input logic fk, input logic [15:0] tag);
    logic [63:0] d;
    d = 64'(tag);
    d[52:50] = mask;
    d[53] = fk;
    return d;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one beat until accepted; push the expected output if it should be forwarded.
  task automatic send(input logic [63:0] d, input logic last, input logic fwd,
                      input logic [2:0] e_oen, input logic e_fk);
    bit ok;
    ok = 1'b0;
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      if (s_axis_tready === 1'b1) ok = 1'b1;
    end
    if (!ok) begin
      tests++;
      fails++;
      $error("FAIL send_timeout: beat %0h never accepted", d);
      s_axis_tvalid = 1'b0;
      return;
    end
    if (fwd) exp_q.push_back('{data: d, last: last, oen: e_oen, fk: e_fk});
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    if (lat_chk) begin
      check("latency_vld", 64'(m_axis_tvalid), 64'(fwd));
      if (fwd) check("latency_dat", m_axis_tdata, d);
    end
  endtask

  task automatic idle(input int n);
    s_axis_tvalid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard: every output handshake must match the oldest expected beat.
  always @(negedge clk) begin
    beat_t o;
    beat_t e;
    if (!rst && m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
      o = '{data: m_axis_tdata, last: m_axis_tlast, oen: oen, fk: fork_enable};
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $error("FAIL unexpected_beat: observed data=%0h last=%0b oen=%0b fk=%0b expected none",
               o.data, o.last, o.oen, o.fk);
      end else begin
        e = exp_q.pop_front();
        assert (o === e) else begin
          fails++;
          $error("FAIL out_beat: observed data=%0h last=%0b oen=%0b fk=%0b expected data=%0h last=%0b oen=%0b fk=%0b",
                 o.data, o.last, o.oen, o.fk, e.data, e.last, e.oen, e.fk);
        end
      end
    end
  end

  initial begin
    #200000;
    $error("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit found;
    rst = 1'b1;
    s_axis_tdata = '0;
    s_axis_tlast = 1'b0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;

    // Reset state
    #12;
    check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_tdata", m_axis_tdata, 64'd0);
    check("rst_tlast", 64'(m_axis_tlast), 64'd0);
    check("rst_oen", 64'(oen), 64'd0);
    check("rst_fork", 64'(fork_enable), 64'd0);
    check("rst_tready", 64'(s_axis_tready), 64'd0);
    check("rst_drop", 64'(drop_count), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rel_tready", 64'(s_axis_tready), 64'd1);

    // Single passthrough: mask 101, fork 1, 4 beats
    send(hdr(3'b101, 1'b1, 16'h0011), 1'b0, 1'b1, 3'b101, 1'b1);
    check("pass_busy_mid", 64'(busy), 64'd1);
    send(64'h0000_0000_0000_0A02, 1'b0, 1'b1, 3'b101, 1'b1);
    send(64'h0000_0000_0000_0A03, 1'b0, 1'b1, 3'b101, 1'b1);
    send(64'h0000_0000_0000_0A04, 1'b1, 1'b1, 3'b101, 1'b1);
    idle(3);
    check("pass_busy_idle", 64'(busy), 64'd0);
    check("pass_q_empty", 64'(exp_q.size()), 64'd0);

    // Drop: zero-mask 2-beat packet (payload has mask bits set), then mask 010 single beat
    send(hdr(3'b000, 1'b1, 16'h0021), 1'b0, 1'b0, 3'b000, 1'b0);
    check("drop_busy", 64'(busy), 64'd1);
    check("drop_cnt_hdr", 64'(drop_count), 64'd1);
    send(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 3'b000, 1'b0);
    send(hdr(3'b010, 1'b0, 16'h0023), 1'b1, 1'b1, 3'b010, 1'b0);
    idle(3);
    check("drop_cnt", 64'(drop_count), 64'd1);
    check("drop_cnt_sat_inst", 64'(sat_drop_count), 64'd1);
    check("drop_q_empty", 64'(exp_q.size()), 64'd0);

    // Backpressure: 8-beat packet, downstream stalls 5 cycles when beat 3 is at the output
    lat_chk = 1'b0;
    fork
      begin
        for (int i = 1; i <= 8; i++) begin
          send((i == 1) ? hdr(3'b011, 1'b1, 16'h0B01) : 64'(16'h0B00 + 16'(i)),
               (i == 8), 1'b1, 3'b011, 1'b1);
        end
      end
      begin
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
          @(posedge clk);
          #1;
          if (m_axis_tvalid === 1'b1 && m_axis_tdata === 64'h0B03) found = 1'b1;
        end
        if (!found) begin
          tests++;
          fails++;
          $error("FAIL bp_wait: beat 3 never reached the output");
        end else begin
          m_axis_tready = 1'b0;
          check("bp_rdy_stall1", 64'(s_axis_tready), 64'd1);
          @(posedge clk);
          #1;
          check("bp_rdy_stall2", 64'(s_axis_tready), 64'd0);
          repeat (4) @(posedge clk);
          #1;
          check("bp_rdy_stall5", 64'(s_axis_tready), 64'd0);
          check("bp_hold_dat", m_axis_tdata, 64'h0B03);
          m_axis_tready = 1'b1;
        end
      end
    join
    lat_chk = 1'b1;
    idle(5);
    check("bp_q_empty", 64'(exp_q.size()), 64'd0);

    // Back-to-back sideband switch: A (001, 2 beats) then B (110, 1 beat)
    send(hdr(3'b001, 1'b0, 16'h0041), 1'b0, 1'b1, 3'b001, 1'b0);
    send(64'h0000_0000_0000_0042, 1'b1, 1'b1, 3'b001, 1'b0);
    check("b2b_oen_a", 64'(oen), 64'(3'b001));
    send(hdr(3'b110, 1'b1, 16'h0043), 1'b1, 1'b1, 3'b110, 1'b1);
    check("b2b_oen_b", 64'(oen), 64'(3'b110));
    idle(3);
    check("b2b_q_empty", 64'(exp_q.size()), 64'd0);

    // Reset mid-packet after beat 2 of a 5-beat packet
    send(hdr(3'b011, 1'b0, 16'h0051), 1'b0, 1'b1, 3'b011, 1'b0);
    send(64'h0000_0000_0000_0052, 1'b0, 1'b1, 3'b011, 1'b0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("mid_rst_tdata", m_axis_tdata, 64'd0);
    check("mid_rst_oen", 64'(oen), 64'd0);
    check("mid_rst_tready", 64'(s_axis_tready), 64'd0);
    check("mid_rst_drop", 64'(drop_count), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rel_tready", 64'(s_axis_tready), 64'd1);
    send(hdr(3'b100, 1'b0, 16'h0055), 1'b1, 1'b1, 3'b100, 1'b0);
    check("mid_new_oen", 64'(oen), 64'(3'b100));
    idle(3);
    check("mid_q_empty", 64'(exp_q.size()), 64'd0);

    // Counter saturation on the 2-bit instance: 1,2,3,3,3
    for (int i = 0; i < 5; i++) begin
      send(hdr(3'b000, 1'b0, 16'(16'h0060 + i)), 1'b1, 1'b0, 3'b000, 1'b0);
      check("sat_cnt2", 64'(sat_drop_count), 64'((i < 3) ? i + 1 : 3));
      check("sat_cnt16", 64'(drop_count), 64'(i + 1));
    end

    idle(5);
    check("final_q_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axis_fork_route_decoder.md
Name: axis_fork_route_decoder

Overview:
- Sits directly upstream of the 3-port AXI4-Stream fork arbiter.
- Decodes the destination mask and fork flag from the first beat (header) of each packet.
- Holds `oen` / `fork_enable` stable for the whole packet, aligned beat-for-beat with the forwarded data.
- Drops packets whose destination mask is zero and counts them.
- Full-throughput, 1-cycle registered datapath with skid buffer.

Parameters:
- `DATA_WIDTH`, 64, stream data width.
- `M_COUNT`, 3, number of fork destinations (width of `oen`).
- `MASK_LSB`, 50, LSB of destination-mask field in header beat; field is `tdata[MASK_LSB +: M_COUNT]`.
- `FORK_BIT`, 53, header bit selecting fork (1) vs single-destination (0) mode.
- `CNT_WIDTH`, 16, width of the drop counter.

Ports:
- `clk`  in  1  clock, all logic rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `s_axis_tdata`  in  DATA_WIDTH  input beat.
- `s_axis_tlast`  in  1  last beat of packet.
- `s_axis_tvalid`  in  1  input valid.
- `s_axis_tready`  out  1  input ready (registered).
- `m_axis_tdata`  out  DATA_WIDTH  output beat, to fork arbiter `s_axis_tdata`.
- `m_axis_tlast`  out  1  output last.
- `m_axis_tvalid`  out  1  output valid.
- `m_axis_tready`  in  1  downstream ready.
- `oen`  out  M_COUNT  per-packet destination mask, valid while `m_axis_tvalid`.
- `fork_enable`  out  1  per-packet fork flag, valid while `m_axis_tvalid`.
- `drop_count`  out  CNT_WIDTH  count of dropped packets, saturating.
- `busy`  out  1  high while mid-packet at input, or while any beat is held internally.

Behaviour:
- **Reset** (async, `rst`=1):
  - `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tdata`=0, `oen`=0, `fork_enable`=0.
  - `s_axis_tready`=0 while `rst` is asserted; `s_axis_tready`=1 from the first clock after release.
  - `drop_count`=0, `busy`=0, skid buffer empty, FSM=HEAD.
  - Reset mid-packet discards all partial state; the next accepted beat is treated as a header.
- **Input acceptance:** a beat is accepted when `s_axis_tvalid && s_axis_tready`.
- **FSM states:** HEAD, PASS, DROP.
  - **HEAD**, on accepted beat:
    - Latch `mask = tdata[MASK_LSB +: M_COUNT]` and `fk = tdata[FORK_BIT]`.
    - If mask≠0: forward the beat with sideband {mask, fk}. If tlast, stay in HEAD; else go to PASS.
    - If mask==0: do not forward the beat; increment `drop_count` (saturate at all-ones) on the header beat. If tlast, stay in HEAD; else go to DROP.
  - **PASS**, on accepted beat: forward the beat with the latched {mask, fk}; on tlast go to HEAD.
  - **DROP**, on accepted beat: discard it; `s_axis_tready` stays governed only by the skid buffer; on tlast go to HEAD.
- **Sideband alignment:** `oen` and `fork_enable` are stored in the output register and skid register together with each beat. They therefore change only on the first output beat of a new packet and never mid-packet at the output.
- **Datapath:** standard 2-entry register slice (output register plus skid register).
  - Latency: 1 cycle from input acceptance to `m_axis_tvalid`.
  - Throughput: 1 beat/cycle when `m_axis_tready`=1.
  - `s_axis_tready` is registered: it is high when the skid register is empty.
  - When `m_axis_tready`=0 with the output full, one more beat is captured into the skid register and then `s_axis_tready` drops the following cycle.
  - The skid drains to the output first when `m_axis_tready` returns; no beat is lost or duplicated.
  - Output holds `m_axis_tdata`, `m_axis_tlast`, `oen` and `fork_enable` stable while `m_axis_tvalid && !m_axis_tready`.
- **Dropped beats** are never written to either register; they consume input bandwidth only.
- **Single-beat packets** (header with tlast): legal in every mode.
- **Back-to-back packets:** tlast of one packet and the header of the next on consecutive cycles are handled with no bubble.
- **`fork_enable` masking:** in single mode (fk=0) `oen` is passed unmodified; the downstream arbiter applies its own `single_mask`.
- **`busy`** = (FSM≠HEAD) or output register valid or skid register valid.

Test Plan:
- **Single passthrough:** header with `tdata[52:50]`=3'b101, `tdata[53]`=1, plus 3 payload beats, tlast on beat 4; `m_axis_tready`=1 → 4 output beats starting 1 cycle after acceptance; `oen`=3'b101 and `fork_enable`=1 on all 4 beats; tlast only on beat 4.
- **Drop:** header mask=0, 2 beats, then packet with mask=3'b010, 1 beat → no output for the first packet; `drop_count`=1; second packet emerges with `oen`=3'b010, `fork_enable`=0.
- **Backpressure:** 8-beat packet; `m_axis_tready` low for 5 cycles starting at beat 3 → `s_axis_tready` low from the 2nd stall cycle; output beats 1..8 in order with no loss or duplication; `oen` constant throughout.
- **Back-to-back sideband switch:** packet A (`oen`=3'b001, 2 beats) immediately followed by packet B (`oen`=3'b110, 1 beat) → 3 consecutive output beats; `oen` changes exactly on B's beat.
- **Reset mid-packet:** assert `rst` after beat 2 of a 5-beat packet → outputs immediately 0; after release, the next beat with mask=3'b100 is decoded as a header with `oen`=3'b100.
- **Counter saturation:** with `CNT_WIDTH`=2, send 5 zero-mask single-beat packets → `drop_count` reads 1, 2, 3, 3, 3.
